// File: rtl/cpu_io_port_if.sv
// Bus and pin bundle between the CPU bus model, the 6510 I/O port and the PLA.
// The master side is the CPU/board; the slave side is the port itself.
interface cpu_io_port_if;
  logic        cpu_en;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic        sel;
  logic [7:0]  rdata;
  logic [5:0]  pin_in;
  logic [5:0]  pin_out;
  logic [5:0]  pin_oe;
  logic        LORAMn;
  logic        HIRAMn;
  logic        CHARENn;

  modport master (
    output cpu_en, addr, rw, wdata, pin_in,
    input  sel, rdata, pin_out, pin_oe, LORAMn, HIRAMn, CHARENn
  );

  modport slave (
    input  cpu_en, addr, rw, wdata, pin_in,
    output sel, rdata, pin_out, pin_oe, LORAMn, HIRAMn, CHARENn
  );
endinterface

// File: rtl/cpu_io_port.sv
// 6510 on-chip I/O port: DDR at $0000, DATA at $0001, banking controls to the PLA,
// and the capacitive fade of the unbonded bits 6/7.
module cpu_io_port #(
  parameter int unsigned FADE_CYCLES = 350000
) (
  input  logic         clk,
  input  logic         rst,
  cpu_io_port_if.slave bus
);

  localparam logic [23:0] LP_FADE = 24'(FADE_CYCLES);

  logic [7:0]  r_ddr;
  logic [7:0]  r_data;
  logic [1:0]  r_charge;
  logic [23:0] r_cnt [2];
  logic        r_loramn;
  logic        r_hiramn;
  logic        r_charenn;

  logic        w_sel;
  logic        w_wr_ddr;
  logic        w_wr_data;
  logic [7:0]  w_ddr_nxt;
  logic [7:0]  w_data_nxt;
  logic [7:0]  w_rd_port;

  assign w_sel      = (bus.addr[15:1] == 15'd0);
  assign w_wr_ddr   = bus.cpu_en & w_sel & ~bus.rw & ~bus.addr[0];
  assign w_wr_data  = bus.cpu_en & w_sel & ~bus.rw &  bus.addr[0];
  assign w_ddr_nxt  = w_wr_ddr  ? bus.wdata : r_ddr;
  assign w_data_nxt = w_wr_data ? bus.wdata : r_data;

  // Port registers, banking outputs and the per-bit fade timers for bits 6/7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ddr     <= 8'h00;
      r_data    <= 8'h00;
      r_charge  <= 2'b00;
      r_cnt[0]  <= 24'd0;
      r_cnt[1]  <= 24'd0;
      r_loramn  <= 1'b1;
      r_hiramn  <= 1'b1;
      r_charenn <= 1'b1;
    end else if (bus.cpu_en) begin
      r_ddr     <= w_ddr_nxt;
      r_data    <= w_data_nxt;
      r_loramn  <= w_ddr_nxt[0] ? w_data_nxt[0] : 1'b1;
      r_hiramn  <= w_ddr_nxt[1] ? w_data_nxt[1] : 1'b1;
      r_charenn <= w_ddr_nxt[2] ? w_data_nxt[2] : 1'b1;
      for (int k = 0; k < 2; k++) begin
        // A reload always beats an expiry landing on the same strobe.
        if (w_wr_data && !r_ddr[6+k]) begin
          r_charge[k] <= bus.wdata[6+k];
          r_cnt[k]    <= LP_FADE;
        end else if (w_wr_ddr && r_ddr[6+k] && !bus.wdata[6+k]) begin
          r_charge[k] <= r_data[6+k];
          r_cnt[k]    <= LP_FADE;
        end else if (w_ddr_nxt[6+k]) begin
          r_cnt[k]    <= 24'd0;
        end else if (r_cnt[k] != 24'd0) begin
          r_cnt[k]    <= r_cnt[k] - 24'd1;
          if (r_cnt[k] == 24'd1) begin
            r_charge[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Read view of $0001: driven bits show DATA, inputs show the pins or the held charge.
  always_comb begin
    w_rd_port[5:0] = (r_ddr[5:0] & r_data[5:0]) | (~r_ddr[5:0] & bus.pin_in);
    w_rd_port[6]   = r_ddr[6] ? r_data[6] : r_charge[0];
    w_rd_port[7]   = r_ddr[7] ? r_data[7] : r_charge[1];
  end

  assign bus.sel     = w_sel;
  assign bus.rdata   = !w_sel ? 8'h00 : (bus.addr[0] ? w_rd_port : r_ddr);
  assign bus.pin_out = r_data[5:0];
  assign bus.pin_oe  = r_ddr[5:0];
  assign bus.LORAMn  = r_loramn;
  assign bus.HIRAMn  = r_hiramn;
  assign bus.CHARENn = r_charenn;

endmodule

// File: tb/tb_cpu_io_port.sv
// Scoreboarded bench for cpu_io_port: driver pushes per-cycle expectations from a
// strobe-timestamp reference model, a separate monitor pops and compares.
module tb_cpu_io_port;

  localparam int F = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_io_port_if bus();

  cpu_io_port #(.FADE_CYCLES(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       chk_rd;
    logic [7:0] rd;
    logic [5:0] po;
    logic [5:0] oe;
    logic [2:0] bank;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: a floating bit keeps its charge for F strobes after the
  // strobe on which it was last charged.
  logic [7:0] m_ddr;
  logic [7:0] m_data;
  logic [1:0] m_cv;
  int         m_set [2];
  int         m_strobes;

  function automatic logic fbit(int k);
    return m_cv[k] && ((m_strobes - m_set[k]) < F);
  endfunction

  task automatic model_reset();
    m_ddr  = 8'h00;
    m_data = 8'h00;
    m_cv   = 2'b00;
  endtask

  task automatic chk(string nm, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic [15:0] a,
                       input logic rw_i, input logic [7:0] wd, input logic [5:0] pi);
    exp_t       e;
    logic [7:0] port;
    @(negedge clk);
    rst        = r;
    bus.cpu_en = en;
    bus.addr   = a;
    bus.rw     = rw_i;
    bus.wdata  = wd;
    bus.pin_in = pi;
    if (r) model_reset();
    for (int i = 0; i < 6; i++) port[i] = m_ddr[i] ? m_data[i] : pi[i];
    for (int k = 0; k < 2; k++) port[6+k] = m_ddr[6+k] ? m_data[6+k] : fbit(k);
    e.sel    = (a[15:1] == 15'd0);
    e.chk_rd = !e.sel || rw_i;
    e.rd     = !e.sel ? 8'h00 : (a[0] ? port : m_ddr);
    e.po     = m_data[5:0];
    e.oe     = m_ddr[5:0];
    e.bank   = {m_ddr[0] ? m_data[0] : 1'b1, m_ddr[1] ? m_data[1] : 1'b1,
                m_ddr[2] ? m_data[2] : 1'b1};
    q.push_back(e);
    if (!r && en) begin
      m_strobes++;
      if (e.sel && !rw_i) begin
        if (a[0]) begin
          for (int k = 0; k < 2; k++)
            if (!m_ddr[6+k]) begin m_cv[k] = wd[6+k]; m_set[k] = m_strobes; end
          m_data = wd;
        end else begin
          for (int k = 0; k < 2; k++)
            if (m_ddr[6+k] && !wd[6+k]) begin m_cv[k] = m_data[6+k]; m_set[k] = m_strobes; end
          m_ddr = wd;
        end
      end
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [5:0] pi);
    cycle(1'b0, 1'b1, a, 1'b1, 8'h00, pi);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] wd);
    cycle(1'b0, 1'b1, a, 1'b0, wd, 6'h00);
  endtask

  // Monitor: compares what the DUT presents each cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sel", {7'd0, bus.sel}, {7'd0, e.sel});
        if (e.chk_rd) chk("rdata", bus.rdata, e.rd);
        chk("pin_out", {2'b00, bus.pin_out}, {2'b00, e.po});
        chk("pin_oe", {2'b00, bus.pin_oe}, {2'b00, e.oe});
        chk("bank", {5'd0, bus.LORAMn, bus.HIRAMn, bus.CHARENn}, {5'd0, e.bank});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_strobes  = 0;
    m_set[0]   = 0;
    m_set[1]   = 0;
    model_reset();
    bus.cpu_en = 1'b0;
    bus.addr   = 16'h0000;
    bus.rw     = 1'b1;
    bus.wdata  = 8'h00;
    bus.pin_in = 6'h00;

    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 6'h00);
    cycle(1'b1, 1'b1, 16'h0001, 1'b1, 8'h00, 6'h00);

    // Direction/data writes and banking.
    wr(16'h0000, 8'h2F);
    wr(16'h0001, 8'h37);
    rd(16'h0001, 6'h10);
    wr(16'h0001, 8'h35);
    rd(16'h0000, 6'h00);
    wr(16'h0001, 8'h37);
    rd(16'h0001, 6'h10);
    rd(16'h0001, 6'h00);
    rd(16'h0101, 6'h3F);
    rd(16'h8000, 6'h3F);

    // Reset mid-run, observed before any clock edge.
    cycle(1'b1, 1'b1, 16'h0000, 1'b1, 8'h00, 6'h00);
    cycle(1'b1, 1'b1, 16'h0001, 1'b1, 8'h00, 6'h15);

    // Fade after DDR bits 7:6 go 1 -> 0.
    wr(16'h0000, 8'hEF);
    wr(16'h0001, 8'hC0);
    wr(16'h0000, 8'h2F);
    for (int i = 0; i < F + 3; i++) rd(16'h0001, 6'h00);

    // Rewrite at strobe 15, a 10-clock stall, and a write ignored without cpu_en.
    wr(16'h0001, 8'h80);
    for (int i = 0; i < 14; i++) rd(16'h0001, 6'h0A);
    wr(16'h0001, 8'h80);
    for (int i = 0; i < 5; i++) rd(16'h0001, 6'h0A);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0001, 1'b1, 8'h00, 6'h0A);
    cycle(1'b0, 1'b0, 16'h0001, 1'b0, 8'h00, 6'h00);
    for (int i = 0; i < F; i++) rd(16'h0001, 6'h0A);

    // Reset at strobe 8 of a fade.
    wr(16'h0001, 8'hC0);
    for (int i = 0; i < 7; i++) rd(16'h0001, 6'h00);
    cycle(1'b1, 1'b1, 16'h0001, 1'b1, 8'h00, 6'h00);
    cycle(1'b1, 1'b1, 16'h0001, 1'b1, 8'h00, 6'h00);
    rd(16'h0000, 6'h00);
    for (int i = 0; i < 4; i++) rd(16'h0001, 6'h00);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      int          pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 4)      a = 16'h0000;
      else if (pick < 8) a = 16'h0001;
      else               a = 16'($urandom);
      cycle(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            a,
            ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
            8'($urandom), 6'($urandom));
    end

    rd(16'h0001, 6'h00);
    repeat (2) @(negedge clk);
    #4;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
